// File: rtl/md_pkg.sv
// md_pkg: opcodes, sequencer state encoding and
// sizing helpers shared by the multiply/divide unit.
package md_pkg;

   localparam logic [2:0] MD_MTLO  = 3'b000;
   localparam logic [2:0] MD_MTHI  = 3'b001;
   localparam logic [2:0] MD_MULT  = 3'b010;
   localparam logic [2:0] MD_MULTU = 3'b011;
   localparam logic [2:0] MD_DIV   = 3'b100;
   localparam logic [2:0] MD_DIVU  = 3'b101;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } md_state_t;

   // Down-counter width able to hold the longest latency.
   function automatic int md_cnt_w(input int m, input int d);
      return $clog2(((m > d) ? m : d) + 1);
   endfunction

   // True for the opcodes that start a multi-cycle run.
   function automatic logic md_is_exec(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) ||
             (op == MD_DIV)  || (op == MD_DIVU);
   endfunction

   // True for the signed variants (mult, div).
   function automatic logic md_is_signed(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request, D-stage hazard query and
// HI/LO read bundle between the pipeline and md_unit.
interface md_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             md_write;
   logic [2:0]       md_op;
   logic             md_sel;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             d_uses_md;
   logic [WIDTH-1:0] md_rdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             stall_req;

   // Pipeline side: issues ops, reads results.
   modport master (
      output start, md_write, md_op, md_sel,
      output rs_val, rt_val, d_uses_md,
      input  md_rdata, hi, lo, busy, stall_req
   );

   // Unit side.
   modport slave (
      input  start, md_write, md_op, md_sel,
      input  rs_val, rt_val, d_uses_md,
      output md_rdata, hi, lo, busy, stall_req
   );
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational product/quotient/remainder on
// latched operands. Ports: i_a, i_b, i_op in; o_prod,
// o_quot, o_rem, o_dz (b==0), o_ovf (MIN/-1) out.
module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic [2:0]         i_op,
   output logic [2*WIDTH-1:0] o_prod,
   output logic [WIDTH-1:0]   o_quot,
   output logic [WIDTH-1:0]   o_rem,
   output logic               o_dz,
   output logic               o_ovf
);
   localparam logic [WIDTH-1:0] MIN_V =
      {1'b1, {(WIDTH-1){1'b0}}};

   logic               w_sgn;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [2*WIDTH-1:0] w_p_mag;
   logic [WIDTH-1:0]   w_q_mag;
   logic [WIDTH-1:0]   w_r_mag;

   // Signed ops run as unsigned magnitudes with the sign
   // re-applied; MIN's magnitude is still exact unsigned.
   assign w_sgn   = md_is_signed(i_op);
   assign w_a_neg = w_sgn & i_a[WIDTH-1];
   assign w_b_neg = w_sgn & i_b[WIDTH-1];
   assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
   assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

   assign w_p_mag = {{WIDTH{1'b0}}, w_a_mag} *
                    {{WIDTH{1'b0}}, w_b_mag};

   assign o_dz  = (i_b == '0);
   assign o_ovf = (i_op == MD_DIV) && (i_a == MIN_V) &&
                  (i_b == '1);

   always_comb begin
      w_q_mag = '0;
      w_r_mag = '0;
      if (!o_dz) begin
         w_q_mag = w_a_mag / w_b_mag;
         w_r_mag = w_a_mag % w_b_mag;
      end
   end

   // Quotient truncates toward zero; remainder follows
   // the dividend's sign.
   assign o_prod = (w_a_neg ^ w_b_neg) ?
                   (~w_p_mag + 1'b1) : w_p_mag;
   assign o_quot = (w_a_neg ^ w_b_neg) ?
                   (~w_q_mag + 1'b1) : w_q_mag;
   assign o_rem  = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multi-cycle mult/div with HI/LO and
// mt/mf access. Ports: clk, reset, bus (md_unit_if.slave).
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  bus
);
   localparam int CW = md_cnt_w(MULT_CYCLES, DIV_CYCLES);
   localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);
   localparam logic [WIDTH-1:0] MIN_V =
      {1'b1, {(WIDTH-1){1'b0}}};

   md_state_t        r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;

   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic               w_dz;
   logic               w_ovf;
   logic               w_busy;

   md_arith #(.WIDTH(WIDTH)) u_arith (
      .i_a    (r_a),
      .i_b    (r_b),
      .i_op   (r_op),
      .o_prod (w_prod),
      .o_quot (w_quot),
      .o_rem  (w_rem),
      .o_dz   (w_dz),
      .o_ovf  (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= MD_MTLO;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.start && md_is_exec(bus.md_op)) begin
                  r_a     <= bus.rs_val;
                  r_b     <= bus.rt_val;
                  r_op    <= bus.md_op;
                  r_cnt   <= bus.md_op[2] ? DC : MC;
                  r_state <= S_RUN;
               end else if (bus.md_write && !bus.start) begin
                  if (bus.md_op == MD_MTLO)
                     r_lo <= bus.rs_val;
                  else if (bus.md_op == MD_MTHI)
                     r_hi <= bus.rs_val;
               end
            end
            S_RUN: begin
               // Requests arriving here are dropped.
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_state <= S_IDLE;
                  if (!r_op[2]) begin
                     {r_hi, r_lo} <= w_prod;
                  end else if (!w_dz) begin
                     if (w_ovf) begin
                        r_hi <= '0;
                        r_lo <= MIN_V;
                     end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_busy        = (r_state == S_RUN);
   assign bus.busy      = w_busy;
   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;
   assign bus.md_rdata  = bus.md_sel ? r_hi : r_lo;
   assign bus.stall_req = bus.d_uses_md &
                          (bus.start | w_busy);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit, default timing
// plus a single-cycle instance.
module tb_md_unit;
   import md_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   md_unit_if #(.WIDTH(32)) bus ();
   md_unit_if #(.WIDTH(32)) bus1 ();

   md_unit #(.WIDTH(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   md_unit #(
      .WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)
   ) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.start = 0; bus.md_write = 0; bus.md_op = 0;
      bus.md_sel = 0; bus.rs_val = 0; bus.rt_val = 0;
      bus.d_uses_md = 0;
      bus1.start = 0; bus1.md_write = 0; bus1.md_op = 0;
      bus1.md_sel = 0; bus1.rs_val = 0; bus1.rt_val = 0;
      bus1.d_uses_md = 0;
   endtask

   task automatic do_start(input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b);
      bus.start = 1; bus.md_write = 1; bus.md_op = op;
      bus.rs_val = a; bus.rt_val = b;
      tick();
      bus.start = 0; bus.md_write = 0;
   endtask

   task automatic do_mt(input logic [2:0] op,
                        input logic [31:0] v);
      bus.md_write = 1; bus.md_op = op; bus.rs_val = v;
      tick();
      bus.md_write = 0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      idle_in();
      reset = 1;
      tick(); tick();
      reset = 0;
      n_chk++;
      if (bus.hi !== 0 || bus.lo !== 0) begin
         n_fail++;
         $display("FAIL reset_hilo: hi=%h lo=%h want 0",
                  bus.hi, bus.lo);
      end
      n_chk++;
      if (bus.busy !== 0 || bus.stall_req !== 0) begin
         n_fail++;
         $display("FAIL reset_busy: busy=%b stall=%b want 0",
                  bus.busy, bus.stall_req);
      end
   endtask

   task automatic test_mult();
      int n;
      do_start(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      // Operand changes during RUN must not matter.
      bus.rs_val = 32'h1111_1111; bus.rt_val = 32'h7;
      wait_idle(n);
      n_chk++;
      if (n !== 5) begin
         n_fail++;
         $display("FAIL mult_busy: got %0d want 5", n);
      end
      n_chk++;
      if (bus.hi !== 32'hFFFF_FFFF ||
          bus.lo !== 32'hFFFF_FFFA) begin
         n_fail++;
         $display("FAIL mult_res: hi=%h lo=%h want ffffffff fffffffa",
                  bus.hi, bus.lo);
      end
      do_start(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      n_chk++;
      if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFF_FFFA) begin
         n_fail++;
         $display("FAIL multu_res: hi=%h lo=%h want 2 fffffffa",
                  bus.hi, bus.lo);
      end
   endtask

   task automatic test_div();
      int n;
      int bad;
      do_mt(MD_MTHI, 32'h0000_00AA);
      do_mt(MD_MTLO, 32'h0000_00BB);
      do_start(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      bad = 0;
      for (int i = 1; i <= 10; i++) begin
         if (bus.busy !== 1 || bus.hi !== 32'hAA ||
             bus.lo !== 32'hBB)
            bad++;
         tick();
      end
      n_chk++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL div_pending: %0d bad cycles want 0",
                  bad);
      end
      n_chk++;
      if (bus.busy !== 0 || bus.lo !== 32'hFFFF_FFFD ||
          bus.hi !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL div_res: busy=%b hi=%h lo=%h want 0 ffffffff fffffffd",
                  bus.busy, bus.hi, bus.lo);
      end
      do_start(MD_DIVU, 32'd7, 32'd0);
      wait_idle(n);
      n_chk++;
      if (n !== 10) begin
         n_fail++;
         $display("FAIL divz_busy: got %0d want 10", n);
      end
      n_chk++;
      if (bus.lo !== 32'hFFFF_FFFD ||
          bus.hi !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL divz_keep: hi=%h lo=%h want ffffffff fffffffd",
                  bus.hi, bus.lo);
      end
   endtask

   task automatic test_mt();
      int n;
      do_mt(MD_MTHI, 32'h1234);
      bus.md_sel = 1;
      #1;
      n_chk++;
      if (bus.md_rdata !== 32'h1234) begin
         n_fail++;
         $display("FAIL mfhi: got %h want 00001234",
                  bus.md_rdata);
      end
      do_mt(MD_MTLO, 32'h5678);
      bus.md_sel = 0;
      #1;
      n_chk++;
      if (bus.md_rdata !== 32'h5678 || bus.hi !== 32'h1234)
      begin
         n_fail++;
         $display("FAIL mflo: got %h hi=%h want 5678 1234",
                  bus.md_rdata, bus.hi);
      end
      // Reserved opcode on start: nothing happens.
      bus.start = 1; bus.md_op = 3'b110;
      bus.rs_val = 32'h9; bus.rt_val = 32'h9;
      tick();
      bus.start = 0;
      n_chk++;
      if (bus.busy !== 0 || bus.lo !== 32'h5678) begin
         n_fail++;
         $display("FAIL reserved: busy=%b lo=%h want 0 5678",
                  bus.busy, bus.lo);
      end
      // mtlo and start during RUN are both dropped.
      do_start(MD_MULT, 32'd2, 32'd3);
      tick();
      do_mt(MD_MTLO, 32'hDEAD);
      bus.start = 1; bus.md_write = 1; bus.md_op = MD_DIV;
      bus.rs_val = 32'd100; bus.rt_val = 32'd7;
      tick();
      bus.start = 0; bus.md_write = 0;
      wait_idle(n);
      n_chk++;
      if (n !== 2) begin
         n_fail++;
         $display("FAIL busy_ignore: tail %0d want 2", n);
      end
      n_chk++;
      if (bus.lo !== 32'd6 || bus.hi !== 32'd0) begin
         n_fail++;
         $display("FAIL mt_in_run: hi=%h lo=%h want 0 6",
                  bus.hi, bus.lo);
      end
      repeat (12) tick();
      n_chk++;
      if (bus.busy !== 0 || bus.lo !== 32'd6) begin
         n_fail++;
         $display("FAIL late_write: busy=%b lo=%h want 0 6",
                  bus.busy, bus.lo);
      end
   endtask

   task automatic test_stall();
      int n;
      bus.d_uses_md = 1;
      bus.start = 1; bus.md_write = 1; bus.md_op = MD_MULT;
      bus.rs_val = 32'd4; bus.rt_val = 32'd5;
      #1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus.stall_req) break;
         n++;
         tick();
         bus.start = 0; bus.md_write = 0;
         #1;
      end
      n_chk++;
      if (n !== 6 || bus.stall_req !== 0) begin
         n_fail++;
         $display("FAIL stall_len: got %0d want 6", n);
      end
      bus.d_uses_md = 0;
      do_start(MD_MULT, 32'd1, 32'd1);
      n_chk++;
      if (bus.busy !== 1 || bus.stall_req !== 0) begin
         n_fail++;
         $display("FAIL stall_nodep: busy=%b stall=%b want 1 0",
                  bus.busy, bus.stall_req);
      end
      wait_idle(n);
   endtask

   task automatic test_reset_run();
      do_mt(MD_MTHI, 32'h77);
      do_mt(MD_MTLO, 32'h88);
      do_start(MD_DIV, 32'd100, 32'd7);
      tick(); tick();
      reset = 1;
      tick();
      reset = 0;
      n_chk++;
      if (bus.busy !== 0 || bus.hi !== 0 || bus.lo !== 0)
      begin
         n_fail++;
         $display("FAIL rst_run: busy=%b hi=%h lo=%h want 0",
                  bus.busy, bus.hi, bus.lo);
      end
      repeat (12) tick();
      n_chk++;
      if (bus.busy !== 0 || bus.hi !== 0 || bus.lo !== 0)
      begin
         n_fail++;
         $display("FAIL rst_late: busy=%b hi=%h lo=%h want 0",
                  bus.busy, bus.hi, bus.lo);
      end
   endtask

   task automatic test_overflow();
      int n;
      do_mt(MD_MTHI, 32'h55);
      do_start(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      n_chk++;
      if (bus.lo !== 32'h8000_0000 || bus.hi !== 0) begin
         n_fail++;
         $display("FAIL ovf: hi=%h lo=%h want 0 80000000",
                  bus.hi, bus.lo);
      end
      bus1.md_write = 1; bus1.md_op = MD_MTHI;
      bus1.rs_val = 32'h55;
      tick();
      bus1.start = 1; bus1.md_op = MD_DIV;
      bus1.rs_val = 32'h8000_0000; bus1.rt_val = 32'hFFFF_FFFF;
      tick();
      bus1.start = 0; bus1.md_write = 0;
      n_chk++;
      if (bus1.busy !== 1 || bus1.hi !== 32'h55) begin
         n_fail++;
         $display("FAIL ovf1_busy: busy=%b hi=%h want 1 55",
                  bus1.busy, bus1.hi);
      end
      tick();
      n_chk++;
      if (bus1.busy !== 0 || bus1.lo !== 32'h8000_0000 ||
          bus1.hi !== 0) begin
         n_fail++;
         $display("FAIL ovf1_res: busy=%b hi=%h lo=%h want 0 0 80000000",
                  bus1.busy, bus1.hi, bus1.lo);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      do_start(MD_MULTU, 32'd5, 32'd6);
      wait_idle(n);
      n_chk++;
      if (bus.hi !== 0 || bus.lo !== 32'd30) begin
         n_fail++;
         $display("FAIL b2b_first: hi=%h lo=%h want 0 1e",
                  bus.hi, bus.lo);
      end
      do_start(MD_DIVU, 32'd30, 32'd4);
      wait_idle(n);
      n_chk++;
      if (n !== 10) begin
         n_fail++;
         $display("FAIL b2b_busy: got %0d want 10", n);
      end
      n_chk++;
      if (bus.hi !== 32'd2 || bus.lo !== 32'd7) begin
         n_fail++;
         $display("FAIL b2b_res: hi=%h lo=%h want 2 7",
                  bus.hi, bus.lo);
      end
   endtask

   initial begin
      reset = 1;
      idle_in();
      test_reset();
      test_mult();
      test_div();
      test_mt();
      test_stall();
      test_reset_run();
      test_overflow();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the pipelined MIPS core. It sits in the E stage beside the ALU and executes mult, multu, div and divu over a configurable number of cycles. It also executes mtlo and mthi writes and serves mfhi/mflo reads from its HI/LO registers. It generates the D-stage stall request for MD-dependent instructions while an operation is in flight, so the hazard unit needs no MD-specific logic.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu; must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  clock. The block has one clock.
- reset  in  1  reset. Synchronous, active-high.
- start  in  1  issue strobe for mult/multu/div/divu; asserted in the cycle the instruction is in E.
- md_write  in  1  E-stage instruction is any MD op: mtlo, mthi, mult, multu, div or divu.
- md_op  in  3  operation: 000 mtlo, 001 mthi, 010 mult, 011 multu, 100 div, 101 divu. 110 and 111 are reserved and cause no action.
- md_sel  in  1  read select: 1 selects HI, 0 selects LO.
- rs_val  in  WIDTH  rs operand: dividend, multiplicand, or mt source.
- rt_val  in  WIDTH  rt operand: divisor or multiplier.
- d_uses_md  in  1  D-stage instruction is an MD op or mfhi/mflo.
- md_rdata  out  WIDTH  combinational read: md_sel ? hi : lo.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in flight.
- stall_req  out  1  d_uses_md & (start | busy), combinational.

## Operation
- State is IDLE or RUN, with a down-counter cnt of width clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- IDLE, start=1 with md_op in {mult, multu, div, divu}:
  - latch rs_val, rt_val and md_op;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, md_write=1, start=0, md_op=mtlo: lo ← rs_val at the edge. md_op=mthi: hi ← rs_val at the edge.
- RUN: cnt decrements each cycle. On the edge where cnt goes 1→0, the block writes HI/LO and returns to IDLE.
- Result rules:
  - mult: {hi, lo} ← signed 2·WIDTH product.
  - multu: {hi, lo} ← unsigned 2·WIDTH product.
  - div: lo ← signed quotient truncated toward zero; hi ← remainder with the sign of the dividend.
  - divu: lo ← unsigned quotient; hi ← unsigned remainder.
  - Divisor = 0: hi and lo are left unchanged. busy still lasts DIV_CYCLES.
  - Signed overflow (most-negative / −1): lo = most-negative value, hi = 0.
- Results use the latched operands only. Changes on rs_val/rt_val during RUN have no effect.
- start, mtlo or mthi arriving during RUN: ignored, and no state changes. Upstream stall_req prevents this case; the verifier treats it as a protocol violation that must still be harmless.
- start with md_op ∉ {mult, multu, div, divu}: no action.
- md_rdata reads the committed HI/LO values. A result that is still pending is never forwarded.

## Timing
- Reset (synchronous): hi=0, lo=0, busy=0, cnt=0, state IDLE. Reset during RUN aborts the operation with no HI/LO write. stall_req follows its equation.
- start sampled at edge E0 → busy=1 in cycles E0+1 … E0+N, with N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO updated at the end of cycle E0+N and visible from E0+N+1.
  - busy=0 from E0+N+1.
- stall_req is high in the start cycle and in every busy cycle. An MD-dependent D instruction therefore advances in the cycle the result becomes visible.
- mtlo/mthi take effect one edge after being sampled. An mflo in the next cycle sees the new value.
- Back-to-back: a new start is accepted in the first cycle with busy=0.

## Structure
- Package md_pkg holds:
  - MD_MTLO … MD_DIVU opcode constants, 3 bits;
  - the IDLE/RUN state encoding;
  - the counter-width function.
- One sub-module, md_arith: combinational signed/unsigned product, quotient and remainder on the latched operands, including the divide-by-zero and overflow flags. Sequencing, counter and HI/LO registers stay in md_unit.

## Test plan
- mult with rs=0xFFFFFFFE (−2), rt=3, defaults: busy for 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- div with rs=−7, rt=2: lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1), visible exactly 11 cycles after start. divu 7/0: hi and lo keep their prior values, busy still lasts 10 cycles.
- mthi 0x1234 in cycle t, then mfhi (md_sel=1) in t+1: md_rdata=0x1234. mtlo issued while busy: lo is not changed.
- d_uses_md=1 held during a mult: stall_req high for exactly 6 cycles (the start cycle plus 5 busy cycles), then low.
- reset asserted in busy cycle 3 of a div: the next cycle has busy=0 and hi=lo=0, and no later write occurs.
- Overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Repeat with MULT_CYCLES=1 and DIV_CYCLES=1: busy lasts a single cycle.
